mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-requester arbiter sharing the single core memory bus between the instruction L1 (fetch stage) and the data L1 (memory stage). It grants one requester at a time and holds the grant until that transaction's `mem_ready`. Ties are broken by alternating priority so neither side starves. A watchdog aborts transactions that never complete.

## Interface
- `DATA_FIRST`, default 1: on a tie straight out of reset, data wins.
- `TIMEOUT_CYCLES`, default 0: maximum cycles per grant before abort. 0 disables the watchdog.
- `clock` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `inst_req` input, `mem_bus_req_t`: request from the instruction cache.
- `inst_resp` output, `mem_bus_resp_t`: response to the instruction cache.
- `data_req` input, `mem_bus_req_t`: request from the data cache.
- `data_resp` output, `mem_bus_resp_t`: response to the data cache.
- `mem_req` output, `mem_bus_req_t`: downstream bus request.
- `mem_resp` input, `mem_bus_resp_t`: downstream bus response.
- `owner` output, 2 bits: current grant. 00 = none, 01 = inst, 10 = data.
- `bus_error` output, 1 bit: sticky flag, set on watchdog abort.
- `contention_cycles` output, 32 bits: count of cycles in which the non-owner had an active request. Saturates at all-ones.

## Operation
- **Active request:** `mem_load_type != NO_LOAD || mem_store_type != NO_STORE`.
- **Idle request:** `NO_LOAD` and `NO_STORE`, with address and data all zero.
- **States:**
  - IDLE: `mem_req` is driven idle.
  - GRANT_INST: `mem_req` = `inst_req`, passed through combinationally.
  - GRANT_DATA: `mem_req` = `data_req`, passed through combinationally.
- **Responses:**
  - The owner's response equals `mem_resp`.
  - The non-owner's response has `mem_ready = 0` and `mem_data = 0`.
  - In IDLE both responses have `mem_ready = 0`.
- **IDLE transitions:**
  - Only one requester active: grant it.
  - Both active: grant the side opposite `last_owner`.
  - Neither active: stay in IDLE.
- **`last_owner` pointer:** 1 bit, updated at every grant release. Reset value is inst when `DATA_FIRST = 1`, so data wins the first tie.
- **GRANT_x with `mem_resp.mem_ready = 1`:** the transaction completes.
  - If the other requester is active, switch directly to its grant with no IDLE bubble.
  - Else, if the same requester is still active, regrant it.
  - Else, go to IDLE.
- **GRANT_x with the owner's request going idle before ready:** release to IDLE next cycle. Any later `mem_ready` is ignored while in IDLE.
- **Watchdog (when `TIMEOUT_CYCLES > 0`):**
  - Counter clears at every grant and increments each cycle the grant is held without ready.
  - When it reaches `TIMEOUT_CYCLES`: set `bus_error`, force IDLE for one cycle, and flip `last_owner` so the other side goes next.
- **`bus_error`:** cleared only by reset.
- **`contention_cycles`:** increments in any cycle where state ≠ IDLE and the non-owner is active. It also increments in IDLE when both sides are active (the loser waits).

## Timing
- **Grant latency:** a request seen in IDLE at cycle N is granted from N+1, and `mem_req` reflects it from N+1. `owner` is registered.
- **Completion:** ready in cycle M is delivered to the owner in M, combinationally. The next grant takes effect at M+1.
- **Requester hold rule:** the owner holds its request stable until it sees ready. The arbiter does not latch request fields.
- **Simultaneous ready and other-side request:** switch at M+1. The completing side cannot win back until the other side's transaction finishes.
- **Reset, at any time, including mid-grant:**
  - state → IDLE, `owner` = 00, `mem_req` idle, both responses not-ready.
  - `bus_error` = 0, `contention_cycles` = 0, watchdog counter = 0, `last_owner` = per `DATA_FIRST`.
  - Any in-flight downstream transaction is abandoned.

## Structure
- **Shared `structures` package:**
  - `mem_bus_req_t` and `mem_bus_resp_t`.
  - `NO_LOAD`, alongside `NO_STORE` and `LOAD_WORD`.
  - New enum `bus_owner_t` {`OWN_NONE`, `OWN_INST`, `OWN_DATA`}, 2 bits.
- **State:** the arbiter state itself is `bus_owner_t`. No separate FSM encoding.
- **Sub-modules:** none. The watchdog counter and contention counter are inline.
- **Placement:** instantiated in the core top between the instruction cache inside `core_IF`, the data cache in the memory stage, and the external memory port.

## Test plan
- **Single requester:** `inst_req` loads word 0x100 in IDLE, memory ready after 3 cycles → `owner` = 01 from the next cycle, `inst_resp.mem_ready` pulses in the same cycle as `mem_resp`, then IDLE. `contention_cycles` = 0.
- **Tie after reset (`DATA_FIRST = 1`):** both active in cycle 0, each transaction 2 cycles long → data granted cycles 1–2, inst granted cycles 3–4 with no IDLE bubble. `contention_cycles` = 3.
- **Continuous requests from both:** 4 transactions → grants alternate D, I, D, I. `data_resp.mem_ready` is never high while `owner` = 01.
- **Owner drops early:** data request goes idle while granted and before ready, then ready arrives → IDLE next cycle, and `data_resp.mem_ready` stays 0 after the release.
- **Watchdog (`TIMEOUT_CYCLES = 8`):** inst granted, `mem_ready` held low → `bus_error` = 1 after 8 cycles, IDLE for one cycle, then a pending data request is granted. `bus_error` stays 1 until reset.
- **Reset mid-grant:** assert reset asynchronously during GRANT_DATA → `owner` = 00, `mem_req` idle, and counters = 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/structures_pkg.sv
// Shared core types: memory bus request/response bundles and bus owner codes.
// Imported by the memory bus arbiter and both L1 caches.
package structures;

    typedef enum logic [2:0] {
        NO_LOAD,
        LOAD_BYTE,
        LOAD_HALF,
        LOAD_WORD,
        LOAD_BYTE_U,
        LOAD_HALF_U
    } load_type_t;

    typedef enum logic [1:0] {
        NO_STORE,
        STORE_BYTE,
        STORE_HALF,
        STORE_WORD
    } store_type_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        load_type_t  mem_load_type;
        store_type_t mem_store_type;
    } mem_bus_req_t;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_data;
    } mem_bus_resp_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_INST = 2'b01,
        OWN_DATA = 2'b10
    } bus_owner_t;

    function automatic logic req_active(input mem_bus_req_t r);
        return (r.mem_load_type != NO_LOAD) || (r.mem_store_type != NO_STORE);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the core memory bus between the instruction L1 and the data L1.
// Ports: clock/reset (async, active-high); inst_req/inst_resp and
// data_req/data_resp toward the caches; mem_req/mem_resp toward memory;
// owner (00 none, 01 inst, 10 data), sticky bus_error, contention_cycles.
module mem_bus_arbiter
    import structures::*;
#(
    parameter bit          DATA_FIRST     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  mem_bus_req_t  inst_req,
    output mem_bus_resp_t inst_resp,
    input  mem_bus_req_t  data_req,
    output mem_bus_resp_t data_resp,
    output mem_bus_req_t  mem_req,
    input  mem_bus_resp_t mem_resp,
    output logic [1:0]    owner,
    output logic          bus_error,
    output logic [31:0]   contention_cycles
);

    bus_owner_t  state_q, state_d;
    // 1 = data owned the bus last, 0 = inst
    logic        last_q, last_d;
    logic [31:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic [31:0] cont_q, cont_d;

    logic       inst_act;
    logic       data_act;
    logic       own_is_data;
    logic       own_act;
    logic       oth_act;
    logic       wd_hit;
    logic       waiting;
    bus_owner_t other_grant;

    assign inst_act    = req_active(inst_req);
    assign data_act    = req_active(data_req);
    assign own_is_data = (state_q == OWN_DATA);
    assign own_act     = own_is_data ? data_act : inst_act;
    assign oth_act     = own_is_data ? inst_act : data_act;
    assign other_grant = own_is_data ? OWN_INST : OWN_DATA;
    assign wd_hit      = (TIMEOUT_CYCLES != 0) &&
                         (wd_q == 32'(TIMEOUT_CYCLES - 1));

    // In IDLE the loser of a tie is the one waiting.
    assign waiting = (state_q == OWN_NONE) ? (inst_act && data_act) : oth_act;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= OWN_NONE;
            last_q  <= ~DATA_FIRST;
            wd_q    <= '0;
            err_q   <= 1'b0;
            cont_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            cont_q  <= cont_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        err_d   = err_q;
        cont_d  = cont_q;

        if (waiting && (cont_q != '1)) begin
            cont_d = cont_q + 32'd1;
        end

        unique case (state_q)
            OWN_NONE: begin
                wd_d = '0;
                if (inst_act && data_act) begin
                    state_d = last_q ? OWN_INST : OWN_DATA;
                end else if (inst_act) begin
                    state_d = OWN_INST;
                end else if (data_act) begin
                    state_d = OWN_DATA;
                end
            end
            OWN_INST, OWN_DATA: begin
                if (mem_resp.mem_ready) begin
                    last_d = own_is_data;
                    wd_d   = '0;
                    if (oth_act) begin
                        state_d = other_grant;
                    end else if (!own_act) begin
                        state_d = OWN_NONE;
                    end
                end else if (!own_act) begin
                    state_d = OWN_NONE;
                    last_d  = own_is_data;
                    wd_d    = '0;
                end else if (wd_hit) begin
                    // Abort: recording the stuck side as last owner
                    // hands the next tie to the other side.
                    state_d = OWN_NONE;
                    last_d  = own_is_data;
                    err_d   = 1'b1;
                    wd_d    = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wd_d = wd_q + 32'd1;
                end
            end
            default: state_d = OWN_NONE;
        endcase
    end

    always_comb begin
        mem_req   = '0;
        inst_resp = '0;
        data_resp = '0;
        unique case (state_q)
            OWN_INST: begin
                mem_req   = inst_req;
                inst_resp = mem_resp;
            end
            OWN_DATA: begin
                mem_req   = data_req;
                data_resp = mem_resp;
            end
            default: begin
                mem_req = '0;
            end
        endcase
    end

    assign owner             = state_q;
    assign bus_error         = err_q;
    assign contention_cycles = cont_q;

endmodule
